// File: rtl/operand_entry.sv
// operand_entry: keypad operand-entry sequencer for the two-digit BCD
// multiplier. Turns debounced key presses into operands A = {s3,s2} and
// B = {s1,s0} and tracks which operand is being edited.
module operand_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down,
    input  logic [3:0] key_code,
    output logic [3:0] store_s0,
    output logic [3:0] store_s1,
    output logic [3:0] store_s2,
    output logic [3:0] store_s3,
    output logic [1:0] state,
    output logic       calc_valid,
    output logic       key_ack
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [3:0] KEY_MUL = 4'hA;
    localparam logic [3:0] KEY_EQU = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;

    state_t     state_q, state_n;
    logic       key_d;
    logic       press;
    logic       is_digit;
    logic [3:0] s0_n, s1_n, s2_n, s3_n;

    // One event per press: rising edge of the held-key level.
    assign press    = key_down & ~key_d;
    assign is_digit = (key_code <= 4'd9);

    // Press-edge history and acknowledge pulse.
    // key_d resets high so a key still held when reset releases is ignored
    // until it has been let go and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_d   <= 1'b1;
            key_ack <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples pre-edge values regardless of statement order.
            key_d   <= key_down;
            key_ack <= press;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ENTER_A;
        else        state_q <= state_n;
    end

    // Operand digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_s0 <= 4'd0;
            store_s1 <= 4'd0;
            store_s2 <= 4'd0;
            store_s3 <= 4'd0;
        end else begin
            store_s0 <= s0_n;
            store_s1 <= s1_n;
            store_s2 <= s2_n;
            store_s3 <= s3_n;
        end
    end

    // Next-state and next-operand decode for the accepted key event.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n = state_q;
        s0_n    = store_s0;
        s1_n    = store_s1;
        s2_n    = store_s2;
        s3_n    = store_s3;
        case (state_q)
            ENTER_A: begin
                if (press) begin
                    if (is_digit) begin
                        s3_n = store_s2;
                        s2_n = key_code;
                    end else if (key_code == KEY_MUL) begin
                        s1_n    = 4'd0;
                        s0_n    = 4'd0;
                        state_n = ENTER_B;
                    end else if (key_code == KEY_CLR) begin
                        {s3_n, s2_n, s1_n, s0_n} = '0;
                    end
                end
            end
            ENTER_B: begin
                if (press) begin
                    if (is_digit) begin
                        s1_n = store_s0;
                        s0_n = key_code;
                    end else if (key_code == KEY_EQU) begin
                        state_n = SHOW;
                    end else if (key_code == KEY_CLR) begin
                        {s3_n, s2_n, s1_n, s0_n} = '0;
                        state_n = ENTER_A;
                    end
                end
            end
            SHOW: begin
                if (press) begin
                    if (is_digit) begin
                        // A digit after a result starts a fresh calculation.
                        s3_n    = 4'd0;
                        s2_n    = key_code;
                        s1_n    = 4'd0;
                        s0_n    = 4'd0;
                        state_n = ENTER_A;
                    end else if (key_code == KEY_CLR) begin
                        {s3_n, s2_n, s1_n, s0_n} = '0;
                        state_n = ENTER_A;
                    end
                end
            end
            default: begin
                // Unused encoding: recover to a clean ENTER_A.
                {s3_n, s2_n, s1_n, s0_n} = '0;
                state_n = ENTER_A;
            end
        endcase
    end

    // Moore outputs derived from the state register.
    always_comb begin
        state      = state_q;
        calc_valid = (state_q == SHOW);
    end

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry: table-driven entry sequence, directed corner
// cases, and random key presses against an arithmetic operand model.
module tb_operand_entry;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_down = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] store_s0, store_s1, store_s2, store_s3;
    logic [1:0] state;
    logic       calc_valid;
    logic       key_ack;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;

    // Reference model: operands as plain integers 0..99, mode 0/1/2.
    int m_a = 0;
    int m_b = 0;
    int m_mode = 0;

    operand_entry dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_down  (key_down),
        .key_code  (key_code),
        .store_s0  (store_s0),
        .store_s1  (store_s1),
        .store_s2  (store_s2),
        .store_s3  (store_s3),
        .state     (state),
        .calc_valid(calc_valid),
        .key_ack   (key_ack)
    );

    always #5 clk = ~clk;

    // Count cycles with key_ack high, sampled away from the active edge.
    always @(negedge clk) if (key_ack === 1'b1) ack_cnt++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void model_key(input int code);
        if (code <= 9) begin
            case (m_mode)
                0: m_a = (m_a % 10) * 10 + code;
                1: m_b = (m_b % 10) * 10 + code;
                default: begin m_a = code; m_b = 0; m_mode = 0; end
            endcase
        end else if (code == 10) begin
            if (m_mode == 0) begin m_b = 0; m_mode = 1; end
        end else if (code == 11) begin
            if (m_mode == 1) m_mode = 2;
        end else if (code == 12) begin
            m_a = 0; m_b = 0; m_mode = 0;
        end
    endfunction

    task automatic check_model(input string name);
        check({name, ".s3"}, int'(store_s3), m_a / 10);
        check({name, ".s2"}, int'(store_s2), m_a % 10);
        check({name, ".s1"}, int'(store_s1), m_b / 10);
        check({name, ".s0"}, int'(store_s0), m_b % 10);
        check({name, ".state"}, int'(state), m_mode);
        check({name, ".calc_valid"}, int'(calc_valid), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_down = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        m_a = 0; m_b = 0; m_mode = 0;
    endtask

    // One press: inputs change on the falling edge; the model follows.
    task automatic press(input logic [3:0] code, input int hold, input int rel,
                         input string name);
        int ack0;
        ack0 = ack_cnt;
        key_code = code;
        key_down = 1'b1;
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (rel) @(negedge clk);
        model_key(int'(code));
        check({name, ".ack"}, ack_cnt - ack0, 1);
    endtask

    typedef struct {
        logic [3:0] code;
        logic [3:0] e3, e2, e1, e0;
        logic [1:0] est;
        logic       ecv;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int ack0;
        vecs[0] = '{4'd4, 4'd0, 4'd4, 4'd0, 4'd0, 2'd0, 1'b0};
        vecs[1] = '{4'd2, 4'd4, 4'd2, 4'd0, 4'd0, 2'd0, 1'b0};
        vecs[2] = '{4'hA, 4'd4, 4'd2, 4'd0, 4'd0, 2'd1, 1'b0};
        vecs[3] = '{4'd1, 4'd4, 4'd2, 4'd0, 4'd1, 2'd1, 1'b0};
        vecs[4] = '{4'd3, 4'd4, 4'd2, 4'd1, 4'd3, 2'd1, 1'b0};
        vecs[5] = '{4'hB, 4'd4, 4'd2, 4'd1, 4'd3, 2'd2, 1'b1};
        vecs[6] = '{4'hE, 4'd4, 4'd2, 4'd1, 4'd3, 2'd2, 1'b1};
        vecs[7] = '{4'hA, 4'd4, 4'd2, 4'd1, 4'd3, 2'd2, 1'b1};

        // Reset state (checked while reset is still asserted).
        #12;
        check("rst.s3", int'(store_s3), 0);
        check("rst.s2", int'(store_s2), 0);
        check("rst.s1", int'(store_s1), 0);
        check("rst.s0", int'(store_s0), 0);
        check("rst.state", int'(state), 0);
        check("rst.calc_valid", int'(calc_valid), 0);
        check("rst.key_ack", int'(key_ack), 0);
        do_reset();

        // Table: 4,2,MUL,1,3,EQU then no-op and ignored MUL in SHOW.
        ack0 = ack_cnt;
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].code, 3, 2, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.s3", i), int'(store_s3), int'(vecs[i].e3));
            check($sformatf("tbl%0d.s2", i), int'(store_s2), int'(vecs[i].e2));
            check($sformatf("tbl%0d.s1", i), int'(store_s1), int'(vecs[i].e1));
            check($sformatf("tbl%0d.s0", i), int'(store_s0), int'(vecs[i].e0));
            check($sformatf("tbl%0d.state", i), int'(state), int'(vecs[i].est));
            check($sformatf("tbl%0d.cv", i), int'(calc_valid), int'(vecs[i].ecv));
        end
        check("tbl.ack_total", ack_cnt - ack0, 8);

        // Three digits in ENTER_A: oldest is dropped.
        press(4'hC, 2, 2, "clr1");
        press(4'd1, 2, 2, "d1");
        press(4'd2, 2, 2, "d2");
        press(4'd3, 2, 2, "d3");
        check("shift.s3", int'(store_s3), 2);
        check("shift.s2", int'(store_s2), 3);
        check("shift.s1", int'(store_s1), 0);
        check("shift.s0", int'(store_s0), 0);

        // Long hold with key_code changing mid-hold: one event, digit 7.
        press(4'hC, 2, 2, "clr2");
        ack0 = ack_cnt;
        key_code = 4'd7;
        key_down = 1'b1;
        repeat (10) @(negedge clk);
        key_code = 4'd5;
        repeat (10) @(negedge clk);
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        model_key(7);
        check("hold.ack", ack_cnt - ack0, 1);
        check("hold.s3", int'(store_s3), 0);
        check("hold.s2", int'(store_s2), 7);

        // From SHOW with 99 x 99: digit starts a new calculation.
        press(4'hC, 2, 2, "clr3");
        press(4'd9, 2, 1, "a9a");
        press(4'd9, 2, 1, "a9b");
        press(4'hA, 2, 1, "mul");
        press(4'd9, 2, 1, "b9a");
        press(4'd9, 2, 1, "b9b");
        press(4'hB, 2, 1, "equ");
        check_model("show99");
        press(4'd6, 2, 2, "new6");
        check("new.s3", int'(store_s3), 0);
        check("new.s2", int'(store_s2), 6);
        check("new.s1", int'(store_s1), 0);
        check("new.s0", int'(store_s0), 0);
        check("new.state", int'(state), 0);
        check("new.cv", int'(calc_valid), 0);
        press(4'hB, 2, 2, "equ_ign");
        check("equ_ign.s2", int'(store_s2), 6);
        check("equ_ign.state", int'(state), 0);
        press(4'hC, 2, 2, "clr4");
        check_model("clr4");
        check("clr4.s2", int'(store_s2), 0);

        // Key held through reset release: no event until re-pressed.
        @(negedge clk);
        key_code = 4'd8;
        key_down = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_a = 0; m_b = 0; m_mode = 0;
        ack0 = ack_cnt;
        repeat (5) @(negedge clk);
        check("heldrst.ack", ack_cnt - ack0, 0);
        check("heldrst.s2", int'(store_s2), 0);
        check("heldrst.state", int'(state), 0);
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        press(4'd8, 2, 2, "repress8");
        check("repress.s2", int'(store_s2), 8);

        // Asynchronous reset mid-ENTER_B with operands 34 x 56.
        press(4'hC, 2, 1, "clr5");
        press(4'd3, 2, 1, "a3");
        press(4'd4, 2, 1, "a4");
        press(4'hA, 2, 1, "mul2");
        press(4'd5, 2, 1, "b5");
        press(4'd6, 2, 1, "b6");
        check_model("pre_async");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.s3", int'(store_s3), 0);
        check("async.s2", int'(store_s2), 0);
        check("async.s1", int'(store_s1), 0);
        check("async.s0", int'(store_s0), 0);
        check("async.state", int'(state), 0);
        check("async.cv", int'(calc_valid), 0);
        check("async.ack", int'(key_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        m_a = 0; m_b = 0; m_mode = 0;

        // Random presses against the model.
        for (int i = 0; i < 200; i++) begin
            press(4'($urandom_range(15, 0)), int'($urandom_range(4, 1)),
                  int'($urandom_range(3, 1)), $sformatf("rnd%0d", i));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Keypad operand-entry sequencer for the two-digit BCD multiplier datapath. Converts debounced keypad presses into two 2-digit BCD operands, A = 10·store_s3 + store_s2 and B = 10·store_s1 + store_s0, and drives them on store_s0..store_s3 directly into the downstream multiplier stage. A small FSM tracks which operand is being edited and flags when a result should be shown.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_down  in  1  debounced key-held level; high for as long as a key is pressed.
- key_code  in  4  code of the held key; valid whenever key_down=1. 0–9 = digit, 4'hA = MUL, 4'hB = EQU, 4'hC = CLR, 4'hD–4'hF = no-op.
- store_s0  out  4  B ones digit (BCD).
- store_s1  out  4  B tens digit (BCD).
- store_s2  out  4  A ones digit (BCD).
- store_s3  out  4  A tens digit (BCD).
- state  out  2  FSM state: 2'd0 ENTER_A, 2'd1 ENTER_B, 2'd2 SHOW.
- calc_valid  out  1  high while state==SHOW.
- key_ack  out  1  one-cycle pulse after each accepted press event, including no-op codes.

## Operation
- Press detection: register key_d <= key_down. Press event = key_down & ~key_d. Exactly one event per press, regardless of hold length. key_code is sampled only on the event cycle.
- ENTER_A:
  - Digit d: store_s3 <= store_s2, store_s2 <= d (shift-in). A third digit discards the oldest.
  - MUL: store_s1 <= 0, store_s0 <= 0, go to ENTER_B.
  - EQU: ignored.
  - CLR: all store_s* <= 0, stay in ENTER_A.
- ENTER_B:
  - Digit d: store_s1 <= store_s0, store_s0 <= d.
  - EQU: go to SHOW. Operands are held.
  - MUL: ignored.
  - CLR: all store_s* <= 0, go to ENTER_A.
- SHOW:
  - Operands are frozen.
  - Digit d: store_s3 <= 0, store_s2 <= d, store_s1 <= 0, store_s0 <= 0, go to ENTER_A. This starts a new calculation.
  - CLR: all store_s* <= 0, go to ENTER_A.
  - MUL, EQU: ignored.
- Codes 4'hD–4'hF: no state or operand change in any state; key_ack still pulses.
- Every store_s* holds only 0–9 by construction. The block never outputs non-BCD values.
- Unused state encoding 2'd3 recovers to ENTER_A with all store_s* cleared on the next clock edge.

## Timing
- Reset (rst_n=0, asynchronous): store_s0..store_s3 = 0, state = ENTER_A, calc_valid = 0, key_ack = 0, key_d = 1.
  - key_d resets to 1 so that a key already held when reset releases produces no event until it is released and pressed again.
- Latency: on the first rising edge where key_down is sampled 1 with key_d=0, the following update together:
  - store_s*, state, and calc_valid;
  - key_ack, which is high for exactly the following cycle.
- Downstream, the multiplier registers its product one further edge later. The product is valid one cycle after calc_valid rises.
- Back-to-back presses require key_down to drop for at least one sampled cycle between them. A 1-cycle low is sufficient.
- A change of key_code while key_down stays high generates no event.
- Reset asserted mid-operation clears everything immediately, with no wait for a clock edge. Entry restarts in ENTER_A.

## Test plan
- Reset, then press 4, 2, MUL, 1, 3, EQU (each held 3 cycles, 2 cycles released).
  - Required: s3..s0 = 4,2,1,3; state 0→1→2; calc_valid=1; key_ack=6 pulses.
- In ENTER_A, press 1, 2, 3.
  - Required: s3=2, s2=3 (oldest digit dropped); B digits stay 0.
- Hold digit 7 for 20 cycles, changing key_code to 5 mid-hold.
  - Required: single event; s2=7, s3=0; one key_ack pulse.
- From SHOW with operands 9,9,9,9, press 6.
  - Required: s3=0, s2=6, s1=0, s0=0; state=ENTER_A; calc_valid=0.
  - Then press EQU: required no change.
  - Then press CLR: required all 0.
- Hold key_down=1 through reset release.
  - Required: no event and no key_ack.
  - Release and re-press 8. Required: s2=8.
- Pulse rst_n low between clock edges during ENTER_B with operands 3,4,5,6.
  - Required: all outputs 0 and state=0 immediately, before the next clk edge.
